// File: rtl/sensor_cmd_pkg.sv
// Shared command/response byte codes and FSM encoding
// for the sensor command dispatcher.
package sensor_cmd_pkg;

  localparam logic [7:0] CMD_STATUS = 8'h00;
  localparam logic [7:0] CMD_TEMP   = 8'h01;
  localparam logic [7:0] CMD_HUM    = 8'h02;
  localparam logic [7:0] CMD_CONT_T = 8'h03;
  localparam logic [7:0] CMD_CONT_H = 8'h04;
  localparam logic [7:0] CMD_STOP   = 8'h05;

  localparam logic [7:0] RSP_STATUS   = 8'h07;
  localparam logic [7:0] RSP_HUM      = 8'h08;
  localparam logic [7:0] RSP_TEMP     = 8'h09;
  localparam logic [7:0] RSP_STOP     = 8'h0A;
  localparam logic [7:0] RSP_SENS_ERR = 8'h1F;
  localparam logic [7:0] RSP_TIMEOUT  = 8'h2F;
  localparam logic [7:0] RSP_BAD_CMD  = 8'hCF;
  localparam logic [7:0] RSP_BAD_ADDR = 8'hEF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_RESPOND,
    S_HOLD
  } state_e;

  typedef enum logic [1:0] {
    K_STATUS,
    K_TEMP,
    K_HUM
  } kind_e;

  // Response pair for a completed (non-timed-out) read.
  function automatic logic [15:0] read_rsp(
    input kind_e      kind,
    input logic       err,
    input logic [7:0] hum,
    input logic [7:0] temp
  );
    logic [15:0] r;
    r = {RSP_STATUS, 8'h00};
    if (err) begin
      r = {RSP_SENS_ERR, 8'h00};
    end else begin
      unique case (kind)
        K_TEMP:  r = {RSP_TEMP, temp};
        K_HUM:   r = {RSP_HUM, hum};
        default: r = {RSP_STATUS, 8'h00};
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/sensor_cmd_dispatcher_cycle_timer.sv
// Loadable down-counter; expire_o pulses once when an armed
// count reaches zero.
module cycle_timer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] value_i,
  output logic             expire_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             armed_q, armed_d;

  assign expire_o = armed_q && (cnt_q == '0);

  always_comb begin
    cnt_d   = cnt_q;
    armed_d = armed_q;
    if (load_i) begin
      cnt_d   = value_i;
      armed_d = 1'b1;
    end else if (clear_i || expire_o) begin
      armed_d = 1'b0;
    end else if (armed_q) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
    end
  end

endmodule

// File: rtl/sensor_cmd_dispatcher.sv
// Decodes host address/command pairs, runs DHT11 reads and
// builds the two-byte response; also runs periodic auto reads.
module sensor_cmd_dispatcher
  import sensor_cmd_pkg::*;
#(
  parameter int unsigned NUM_SENSORS    = 32,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  parameter int unsigned CONT_PERIOD    = 100_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_cmd,
  output logic       busy,
  output logic       sens_start,
  output logic [4:0] sens_sel,
  input  logic       sens_done,
  input  logic       sens_error,
  input  logic [7:0] sens_hum,
  input  logic [7:0] sens_temp,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_code,
  output logic [7:0] rsp_data
);

  localparam logic [31:0] TO_LOAD  = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] PER_LOAD = 32'(CONT_PERIOD - 1);

  state_e      state_q, state_d;
  logic [4:0]  sel_q, sel_d;
  kind_e       kind_q, kind_d;
  logic        cur_cont_q, cur_cont_d;
  logic [7:0]  code_q, code_d;
  logic [7:0]  data_q, data_d;
  logic [7:0]  rsp_code_q, rsp_code_d;
  logic [7:0]  rsp_data_q, rsp_data_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        cont_on_q, cont_on_d;
  logic [4:0]  cont_addr_q, cont_addr_d;
  kind_e       cont_kind_q, cont_kind_d;
  logic        tick_pend_q, tick_pend_d;

  logic        to_load, to_clear, to_exp;
  logic        per_load, per_clear, per_exp;
  logic        addr_bad, tick;
  logic [15:0] rd_rsp;

  cycle_timer #(.WIDTH(32)) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (to_load),
    .clear_i  (to_clear),
    .value_i  (TO_LOAD),
    .expire_o (to_exp)
  );

  cycle_timer #(.WIDTH(32)) u_period (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (per_load),
    .clear_i  (per_clear),
    .value_i  (PER_LOAD),
    .expire_o (per_exp)
  );

  assign busy       = (state_q != S_IDLE);
  assign sens_start = (state_q == S_START);
  assign sens_sel   = sel_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_code   = rsp_code_q;
  assign rsp_data   = rsp_data_q;

  assign addr_bad = {24'd0, req_addr} >= NUM_SENSORS;
  assign tick     = tick_pend_q || per_exp;
  assign rd_rsp   = read_rsp(kind_q, sens_error,
                             sens_hum, sens_temp);

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    kind_d      = kind_q;
    cur_cont_d  = cur_cont_q;
    code_d      = code_q;
    data_d      = data_q;
    rsp_code_d  = rsp_code_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = rsp_valid_q;
    cont_on_d   = cont_on_q;
    cont_addr_d = cont_addr_q;
    cont_kind_d = cont_kind_q;
    tick_pend_d = tick_pend_q || per_exp;
    to_load     = 1'b0;
    to_clear    = 1'b0;
    per_load    = 1'b0;
    per_clear   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (addr_bad) begin
            code_d  = RSP_BAD_ADDR;
            data_d  = req_addr;
            state_d = S_RESPOND;
          end else begin
            case (req_cmd)
              CMD_STATUS, CMD_TEMP, CMD_HUM: begin
                state_d    = S_START;
                sel_d      = req_addr[4:0];
                cur_cont_d = 1'b0;
                to_load    = 1'b1;
                kind_d     = (req_cmd == CMD_TEMP) ? K_TEMP :
                             (req_cmd == CMD_HUM)  ? K_HUM  :
                                                     K_STATUS;
              end
              CMD_CONT_T, CMD_CONT_H: begin
                state_d     = S_START;
                sel_d       = req_addr[4:0];
                cur_cont_d  = 1'b1;
                to_load     = 1'b1;
                kind_d      = (req_cmd == CMD_CONT_T) ? K_TEMP
                                                      : K_HUM;
                cont_on_d   = 1'b1;
                cont_addr_d = req_addr[4:0];
                cont_kind_d = kind_d;
                per_load    = 1'b1;
                tick_pend_d = 1'b0;
              end
              CMD_STOP: begin
                cont_on_d   = 1'b0;
                per_clear   = 1'b1;
                tick_pend_d = 1'b0;
                code_d      = RSP_STOP;
                data_d      = 8'h00;
                state_d     = S_RESPOND;
              end
              default: begin
                code_d  = RSP_BAD_CMD;
                data_d  = req_cmd;
                state_d = S_RESPOND;
              end
            endcase
          end
        end else if (tick && cont_on_q) begin
          state_d     = S_START;
          sel_d       = cont_addr_q;
          kind_d      = cont_kind_q;
          cur_cont_d  = 1'b1;
          to_load     = 1'b1;
          per_load    = 1'b1;
          tick_pend_d = 1'b0;
        end else if (!cont_on_q) begin
          tick_pend_d = 1'b0;
        end
      end
      S_START: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A done pulse in the expiry cycle still counts as a read.
        if (sens_done) begin
          {code_d, data_d} = rd_rsp;
          to_clear         = 1'b1;
          state_d          = S_RESPOND;
        end else if (to_exp) begin
          code_d   = RSP_TIMEOUT;
          data_d   = 8'h00;
          to_clear = 1'b1;
          state_d  = S_RESPOND;
          if (cur_cont_q) begin
            cont_on_d   = 1'b0;
            per_clear   = 1'b1;
            tick_pend_d = 1'b0;
          end
        end
      end
      S_RESPOND: begin
        rsp_code_d  = code_q;
        rsp_data_d  = data_q;
        rsp_valid_d = 1'b1;
        state_d     = S_HOLD;
      end
      S_HOLD: begin
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sel_q       <= '0;
      kind_q      <= K_STATUS;
      cur_cont_q  <= 1'b0;
      code_q      <= '0;
      data_q      <= '0;
      rsp_code_q  <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      cont_on_q   <= 1'b0;
      cont_addr_q <= '0;
      cont_kind_q <= K_STATUS;
      tick_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      kind_q      <= kind_d;
      cur_cont_q  <= cur_cont_d;
      code_q      <= code_d;
      data_q      <= data_d;
      rsp_code_q  <= rsp_code_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      cont_on_q   <= cont_on_d;
      cont_addr_q <= cont_addr_d;
      cont_kind_q <= cont_kind_d;
      tick_pend_q <= tick_pend_d;
    end
  end

endmodule

// File: doc/sensor_cmd_dispatcher.md
# sensor_cmd_dispatcher

Decodes each received address/command byte pair from the UART two-byte receiver and runs the requested DHT11 sensor transaction. Builds the two-byte response (code, data) for the UART two-byte transmitter. Sits between the RX pair register (upstream) and the TX pair register (downstream); it owns the single sensor-interface request port and a periodic "continuous read" mode.

## Interface
- NUM_SENSORS, 32: valid addresses are 0..NUM_SENSORS-1.
- TIMEOUT_CYCLES, 50_000_000: maximum wait for `sens_done` after `sens_start` (1 s at 50 MHz).
- CONT_PERIOD, 100_000_000: cycles between automatic reads in continuous mode (2 s).
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  one-cycle pulse: a complete address/command pair is present.
- req_addr  in  8  sensor address.
- req_cmd  in  8  command byte.
- busy  out  1  high whenever state ≠ IDLE.
- sens_start  out  1  one-cycle pulse: start a read on `sens_sel`.
- sens_sel  out  5  sensor index; held stable from `sens_start` until the transaction ends.
- sens_done  in  1  one-cycle pulse: the read finished; data/error valid this cycle.
- sens_error  in  1  checksum/bus error flag; qualified by `sens_done`.
- sens_hum  in  8  integer humidity.
- sens_temp  in  8  integer temperature.
- rsp_valid  out  1  response pair available; held until accepted.
- rsp_ready  in  1  TX side can take a pair.
- rsp_code  out  8  first response byte.
- rsp_data  out  8  second response byte.

## Operation
- Commands:
  - 0x00 status → 0x07/0x00 if the sensor read is OK.
  - 0x01 temperature → 0x09/temp.
  - 0x02 humidity → 0x08/hum.
  - 0x03 start continuous temperature, then reads as for 0x01.
  - 0x04 start continuous humidity, then reads as for 0x02.
  - 0x05 stop continuous → 0x0A/0x00; no sensor access.
- Read failures on any sensor command:
  - `sens_error` → 0x1F/0x00.
  - Timeout → 0x2F/0x00; a timeout on a continuous read also clears continuous mode.
- Request rejects, no sensor access:
  - Address ≥ NUM_SENSORS → 0xEF/req_addr; checked first.
  - Unknown command → 0xCF/req_cmd.
- States and transitions:
  - IDLE → START on accepted request or continuous tick.
  - START (issue `sens_start`) → WAIT.
  - WAIT → RESPOND on `sens_done` or timeout.
  - RESPOND (load rsp regs) → HOLD.
  - HOLD → IDLE when `rsp_valid && rsp_ready`.
  - Reject and stop commands go IDLE → RESPOND directly.
- Continuous mode:
  - Registers `cont_on`, `cont_addr`, `cont_kind` (temp/hum).
  - Period counter runs only while `cont_on`; it reloads on each auto read and on each 0x03/0x04.
  - Expiry while not in IDLE is latched as a pending tick and served on the next IDLE cycle.
  - 0x03/0x04 to a new address replace the previous continuous target.
- `req_valid` while busy is dropped silently; the upstream stage must not rely on queuing.
- Same-cycle `req_valid` and pending tick in IDLE: the host request wins; the tick stays pending.
- `sens_done` outside WAIT is ignored.
- Reset:
  - State IDLE.
  - All outputs 0.
  - `cont_on` = 0, counters 0, pending tick cleared.
  - Reset mid-transaction abandons it with no response emitted.

## Timing
- `req_valid` sampled at edge k (IDLE):
  - `sens_start` high in cycle k+1, with `sens_sel` = req_addr[4:0].
  - Reject/stop commands: `rsp_valid` high from cycle k+2.
- `sens_done` sampled at edge m: `rsp_valid` high from cycle m+2.
- Timeout:
  - Counter starts in the `sens_start` cycle.
  - Fires when the count reaches TIMEOUT_CYCLES−1 with no `sens_done`.
  - `sens_done` in the firing cycle wins over the timeout.
- `rsp_code`/`rsp_data` are stable while `rsp_valid` is high.
- `rsp_valid` falls the cycle after acceptance.
- Earliest next request accepted: the cycle after HOLD exits.

## Structure
- Shared package `sensor_cmd_pkg`:
  - command codes 0x00–0x05;
  - response codes 0x07/0x08/0x09/0x0A/0x1F/0x2F/0xCF/0xEF;
  - state encoding.
- Sub-module `cycle_timer`: loadable down-counter with an expire pulse. Two instances, one for the timeout and one for the continuous period.

## Test plan
- Reset, then req addr 0x03 cmd 0x01; model returns `sens_done` with temp 0x19 after 100 cycles → `sens_sel`=3, rsp 0x09/0x19, exact k+1 and m+2 cycle checks.
- Req addr 0x40 cmd 0x01 → rsp 0xEF/0x40, no `sens_start`; req addr 0x02 cmd 0x7E → 0xCF/0x7E.
- Model never answers (TIMEOUT_CYCLES=1000) → rsp 0x2F/0x00 at cycle 1000 after `sens_start`; a late `sens_done` is ignored.
- Cmd 0x04 addr 1 (CONT_PERIOD=500) → immediate read, then auto reads every ~500 cycles giving 0x08/hum; cmd 0x05 → 0x0A/0x00 and no further `sens_start`.
- Hold `rsp_ready`=0 for 50 cycles → `rsp_valid` and data stable; a `req_valid` pulse during HOLD is dropped; `rst_n` low in WAIT → all outputs 0, no response after release.
